uart_rx_buffered: RTL
=====================

Name: uart_rx_buffered

Overview:
Synthesizable UART receiver for the SoC console path. It pairs with the UART transmitter that the simulation console drives onto the board's uart_txd_in pin. The block oversamples the serial line, deframes 8N1 characters and buffers them in a small FIFO. It presents the bytes to the core/MMIO side over a ready/valid interface and flags framing errors and overflows.

Parameters:
CLOCK_FREQ, 100_000_000, input clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit (even, >= 8)
FIFO_DEPTH, 8, receive FIFO entries (power of two, >= 2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
rxd  input  1  serial line, idle high, asynchronous to clock
rx_data  output  8  byte at FIFO head
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts head when rx_valid && rx_ready
frame_error  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: completed byte dropped, FIFO full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values: rx_data 0, rx_valid 0, frame_error 0, overflow 0, fifo_count 0. FSM goes to IDLE. Synchronizer flops are set to 1.
- rxd passes through a 2-flop synchronizer before any use. All logic uses the synchronized value rxs.
- Tick divider: DIV = round(CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)), which is 54 at the defaults. A free counter emits a one-cycle tick every DIV clocks. It reloads on the start-bit edge so that sampling phase aligns to the edge.
- FSM states and transitions:
  - IDLE: a falling edge on rxs moves to START and clears the tick counter and sample counter.
  - START: at mid-bit (tick OVERSAMPLE/2), if the sample is high, treat it as a glitch and return to IDLE with no output. Otherwise go to DATA with bit index 0.
  - DATA: sample at mid-bit every OVERSAMPLE ticks. Data is LSB first into an 8-bit shift register. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - High: push the byte into the FIFO if not full. If full, pulse overflow and discard the byte; the FIFO contents are unchanged.
    - Low: pulse frame_error and discard the byte. Wait in STOP until rxs is high (break handling), then go to IDLE.
    - After a good stop sample, go directly to IDLE. A new start edge is accepted from the next cycle, which tolerates back-to-back characters with 0.5-bit stop margin.
- FIFO behaviour:
  - Circular buffer with pointers one bit wider than the index. Wrap-around is natural.
  - rx_data is a registered head (show-ahead). rx_valid rises the cycle after the push.
  - A push and a pop in the same cycle leave fifo_count unchanged, and are legal when full. In that case the pop frees the slot, the push is accepted and no overflow is raised.
  - A pop while empty is ignored.
- Latency: from the start-bit falling edge on rxd to rx_valid is about 9.5 bit times plus 3 clocks (2 synchronizer + 1 push).
- Asserting reset mid-frame aborts the character. Pending FIFO data is lost.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each bit value is the majority of the three samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. This applies to start, data and stop bits.
- Not defined: a single sample at tick OVERSAMPLE/2. The latency is identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum uart_rx_state_e {IDLE, START, DATA, STOP}
  - localparam function for DIV computation
  - UART_DATA_BITS=8
- One sub-module: uart_rx_fifo, a parameterized show-ahead sync FIFO with push, pop, full, empty and count. It is reused later by the TX side.

Test Plan:
1. Reset, rxd held high for 2000 cycles -> rx_valid 0, fifo_count 0, no error pulses.
2. Send 0xCA then 0xCA at 115200 baud (864 clocks/bit), rx_ready=1 -> two bytes 0xCA accepted, each about 8210 clocks after its start edge; frame_error never pulses.
3. Send 0x00..0x08 (9 bytes) with rx_ready=0 -> fifo_count saturates at 8, overflow pulses once on the 9th stop bit; draining yields 0x00..0x07 in order.
4. Send 0x55 with the stop bit forced low, then hold the line low 3 bit times -> frame_error pulses once, no byte pushed. After the line returns high, 0xA5 is received correctly.
5. Glitch: drive rxd low for 200 clocks (less than half a bit) -> no byte and no error; the FSM returns to IDLE. With UART_RX_MAJORITY_VOTE_EN, a 1-clock low spike at mid-bit of data bit 3 of 0xFF still yields 0xFF.
6. Assert reset mid-byte (during DATA bit 4) with 2 bytes in the FIFO -> all outputs return to reset values. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and baud divider helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int den;
        den = baud * os;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO with a registered head; shared by the UART RX and TX paths.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             push_ok_s, pop_ok_s;

    assign rd_data = head_q;
    assign empty   = ~valid_q;
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;

    // Pointer, occupancy and head-of-queue next state.
    always_comb begin
        pop_ok_s  = pop & valid_q;
        push_ok_s = push & (~full | pop_ok_s);
        wr_ptr_d  = wr_ptr_q + (AW + 1)'(push_ok_s);
        rd_ptr_d  = rd_ptr_q + (AW + 1)'(pop_ok_s);
        count_d   = count_q + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_ok_s);
        valid_d   = (count_d != '0);
        // The new head is the entry being written only when it becomes the sole entry.
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_ok_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_d = wr_data;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 UART receiver feeding a show-ahead FIFO with ready/valid output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote per bit.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    logic sync1_q, rxs_q, rxs_prev_q;

    uart_rx_state_e            state_q, state_d;
    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]             samp_cnt_q, samp_cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      s_early_q, s_early_d;
    logic                      s_mid_q, s_mid_d;
    logic                      brk_q, brk_d;
    logic                      frame_error_q, frame_error_d;
    logic                      overflow_q, overflow_d;
    logic                      tick_s, fall_s, decide_s, bit_val_s, push_s;
    logic                      fifo_empty_s, fifo_full_s;

    // Two-flop synchronizer plus an edge-detect history flop, all idle-high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Decision is taken on the tick after mid-bit in both builds so latency never depends on voting.
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        brk_d         = brk_q;
        frame_error_d = 1'b0;
        overflow_d    = 1'b0;
        push_s        = 1'b0;
        fall_s        = rxs_prev_q & ~rxs_q;
        tick_s        = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d    = tick_s ? '0 : tick_cnt_q + TW'(1);
        if (tick_s) begin
            samp_cnt_d = (samp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + SW'(1);
        end else begin
            samp_cnt_d = samp_cnt_q;
        end
        s_early_d = (tick_s && samp_cnt_q == SW'(OVERSAMPLE / 2 - 2)) ? rxs_q : s_early_q;
        s_mid_d   = (tick_s && samp_cnt_q == SW'(OVERSAMPLE / 2 - 1)) ? rxs_q : s_mid_q;
        decide_s  = tick_s && (samp_cnt_q == SW'(OVERSAMPLE / 2)) && !brk_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        bit_val_s = (s_early_q & s_mid_q) | (s_early_q & rxs_q) | (s_mid_q & rxs_q);
`else
        bit_val_s = s_mid_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (decide_s) begin
                    state_d   = bit_val_s ? IDLE : DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (decide_s) begin
                    shift_d   = {bit_val_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = (bit_idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (brk_q) begin
                    // Line held low after a bad stop bit: wait for idle before rearming.
                    state_d = rxs_q ? IDLE : STOP;
                    brk_d   = ~rxs_q;
                end else if (decide_s) begin
                    if (bit_val_s) begin
                        state_d    = IDLE;
                        push_s     = ~fifo_full_s | rx_ready;
                        overflow_d = fifo_full_s & ~rx_ready;
                    end else begin
                        frame_error_d = 1'b1;
                        brk_d         = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                brk_d   = 1'b0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            samp_cnt_q    <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= '0;
            s_early_q     <= 1'b1;
            s_mid_q       <= 1'b1;
            brk_q         <= 1'b0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            s_early_q     <= s_early_d;
            s_mid_q       <= s_mid_d;
            brk_q         <= brk_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;
    assign rx_valid    = ~fifo_empty_s;

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push    (push_s),
        .wr_data (shift_q),
        .pop     (rx_ready),
        .rd_data (rx_data),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count)
    );

endmodule
